// File: rtl/prog_loader_if.sv
// Host word stream and instruction-memory write port of the program loader.
// master: the host side (drives words, sees ready and the write port).
// slave : the loader (accepts words, drives ready and the write port).
interface prog_loader_if #(
    parameter int unsigned AW = 8
);
    logic          in_valid;
    logic [15:0]   in_data;
    logic          in_ready;
    logic          ext_we;
    logic [AW-1:0] ext_addr;
    logic [15:0]   ext_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, ext_we, ext_addr, ext_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, ext_we, ext_addr, ext_data
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader for the 16-bit RISC core: streams host words into the core's
// instruction memory, holds the core in reset while loading, releases it after
// RST_HOLD cycles and waits for the core's done flag.
// Optional run-time watchdog is compiled in with the WATCHDOG_EN macro; it adds
// the wdt_trip output port. WDT_CYCLES is assumed to be at least 1.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | core held in reset, waiting for start
// LOAD   | accepting host words, one write per accepted word
// HOLD   | halt word written, core still in reset for RST_HOLD cycles
// RUN    | core released, waiting for cpu_done (or watchdog expiry)
// DONE   | core halted, reset kept released so its outputs stay visible
module prog_loader #(
    parameter int unsigned AW         = 8,
    parameter int unsigned RST_HOLD   = 9,
    parameter logic [15:0] HLT_WORD   = 16'hE001,
    parameter int unsigned WDT_CYCLES = 100000
) (
    input  logic          clk,
    input  logic          PC_rst,
    input  logic          start,
    prog_loader_if.slave  bus,
    input  logic          cpu_done,
    output logic          cpu_rst_n,
    output logic          busy,
    output logic          finished,
    output logic          load_err,
    output logic [AW:0]   word_count
`ifdef WATCHDOG_EN
    ,
    output logic          wdt_trip
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN,
        S_DONE
    } state_t;

    // One down-counter serves both the reset hold and the watchdog, so it is
    // sized for the longer of the two intervals.
    localparam int unsigned TMAX = (RST_HOLD > WDT_CYCLES) ? RST_HOLD : WDT_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam logic [AW:0] CAP  = {1'b1, {AW{1'b0}}};

    state_t        state_q;
    logic [AW-1:0] addr_q;
    logic [TW-1:0] tmr_q;
    logic          in_ready_q;
    logic          ext_we_q;
    logic [AW-1:0] ext_addr_q;
    logic [15:0]   ext_data_q;
    logic          cpu_rst_n_q;
    logic          busy_q;
    logic          finished_q;
    logic          load_err_q;
    logic [AW:0]   word_count_q;
`ifdef WATCHDOG_EN
    logic          wdt_trip_q;
`endif

    logic          accept;
    assign accept = bus.in_valid & in_ready_q;

    // Sequencer: state and every output are registered together so each output
    // changes on the same edge as the state that defines it.
    always_ff @(posedge clk or negedge PC_rst) begin
        if (!PC_rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            tmr_q        <= '0;
            in_ready_q   <= 1'b0;
            ext_we_q     <= 1'b0;
            ext_addr_q   <= '0;
            ext_data_q   <= '0;
            cpu_rst_n_q  <= 1'b0;
            busy_q       <= 1'b0;
            finished_q   <= 1'b0;
            load_err_q   <= 1'b0;
            word_count_q <= '0;
`ifdef WATCHDOG_EN
            wdt_trip_q   <= 1'b0;
`endif
        end else begin
            ext_we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q      <= S_LOAD;
                        addr_q       <= '0;
                        word_count_q <= '0;
                        load_err_q   <= 1'b0;
                        in_ready_q   <= 1'b1;
                        cpu_rst_n_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        finished_q   <= 1'b0;
`ifdef WATCHDOG_EN
                        wdt_trip_q   <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        ext_we_q   <= 1'b1;
                        ext_data_q <= bus.in_data;
                        ext_addr_q <= addr_q;
                        addr_q     <= addr_q + 1'b1;
                        if (word_count_q != CAP) begin
                            word_count_q <= word_count_q + 1'b1;
                        end
                        // Halt word takes priority: a halt landing in the last
                        // free slot is a complete program, not an overflow.
                        if (bus.in_data == HLT_WORD) begin
                            state_q    <= S_HOLD;
                            in_ready_q <= 1'b0;
                            tmr_q      <= TW'(RST_HOLD);
                        end else if (word_count_q == CAP - 1'b1) begin
                            state_q    <= S_IDLE;
                            in_ready_q <= 1'b0;
                            load_err_q <= 1'b1;
                            busy_q     <= 1'b0;
                        end
                    end
                end
                S_HOLD: begin
                    // The write cycle itself is not counted: the core sees
                    // RST_HOLD further reset cycles after its last word lands.
                    if (tmr_q == '0) begin
                        state_q     <= S_RUN;
                        cpu_rst_n_q <= 1'b1;
`ifdef WATCHDOG_EN
                        tmr_q       <= TW'(WDT_CYCLES);
`endif
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                S_RUN: begin
                    if (cpu_done) begin
                        state_q    <= S_DONE;
                        finished_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
`ifdef WATCHDOG_EN
                    else if (tmr_q <= TW'(1)) begin
                        state_q     <= S_IDLE;
                        cpu_rst_n_q <= 1'b0;
                        busy_q      <= 1'b0;
                        wdt_trip_q  <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
`endif
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.ext_we   = ext_we_q;
    assign bus.ext_addr = ext_addr_q;
    assign bus.ext_data = ext_data_q;
    assign cpu_rst_n    = cpu_rst_n_q;
    assign busy         = busy_q;
    assign finished     = finished_q;
    assign load_err     = load_err_q;
    assign word_count   = word_count_q;
`ifdef WATCHDOG_EN
    assign wdt_trip     = wdt_trip_q;
`endif

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream stage of the 16-bit RISC core.
- Accepts a stream of 16-bit instruction words from a host over a valid/ready handshake and writes them into the core's instruction memory through the core's external write port (ext_data / ext_we, plus a write address).
- Holds the core's PC reset low while loading, releases it after a programmable hold time, and then watches the core's done flag.

Parameters:
- AW, 8, instruction-memory address width; capacity is 2^AW words.
- RST_HOLD, 9, cycles the core reset stays low after the last word is written.
- HLT_WORD, 16'hE001, opcode that terminates a load session.
- WDT_CYCLES, 100000, run-time limit in cycles; used only with WATCHDOG_EN.

Ports:
- clk  in  1  system clock, rising edge.
- PC_rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a load session.
- in_valid  in  1  host word valid.
- in_data  in  16  host instruction word.
- in_ready  out  1  loader can accept a word.
- ext_we  out  1  instruction-memory write enable to the core.
- ext_addr  out  AW  instruction-memory write address.
- ext_data  out  16  instruction-memory write data.
- cpu_rst_n  out  1  drives the core's PC_rst; active-low.
- cpu_done  in  1  core halted (core's done output).
- busy  out  1  high in LOAD, HOLD and RUN.
- finished  out  1  high in DONE.
- load_err  out  1  sticky; set when the program overflows memory.
- word_count  out  AW+1  number of words written in the current session.

Behaviour:
- Reset (PC_rst=0, asynchronous):
  - State goes to IDLE.
  - ext_we=0, ext_addr=0, ext_data=0, in_ready=0, cpu_rst_n=0, busy=0, finished=0, load_err=0, word_count=0.
  - An active reset overrides any state immediately, including mid-load.
- States: IDLE, LOAD, HOLD, RUN, DONE. All outputs are registered.
- IDLE:
  - cpu_rst_n=0, in_ready=0.
  - start=1 -> LOAD; clear addr, word_count and load_err.
- LOAD:
  - in_ready=1 and cpu_rst_n=0.
  - A handshake is in_valid & in_ready on a clock edge.
  - On the cycle after a handshake: ext_we=1, ext_data=captured word, ext_addr=current addr. Then addr++ and word_count++.
  - ext_we is high for exactly one cycle per accepted word.
  - Throughput is one word per cycle.
  - An accepted word equal to HLT_WORD is written normally. in_ready drops on the cycle after that handshake; state -> HOLD.
  - When word 2^AW is accepted and is not HLT_WORD: write it, set load_err=1, go to IDLE, keep cpu_rst_n=0.
  - start pulses during LOAD are ignored.
- HOLD:
  - cpu_rst_n=0 and in_ready=0.
  - The counter runs RST_HOLD cycles, then the state goes to RUN.
  - cpu_rst_n rises on the first RUN cycle.
- RUN:
  - cpu_rst_n=1.
  - cpu_done=1 -> DONE.
  - in_valid is ignored; in_ready=0.
- DONE:
  - cpu_rst_n stays 1 so the core's OutR remains observable.
  - finished=1.
  - start=1 -> LOAD: cpu_rst_n falls on the next cycle, finished clears, addr and word_count reset to 0.
- Simultaneous events:
  - start and cpu_done in the same cycle in RUN: cpu_done wins; state -> DONE.
  - start in DONE is handled as above.
- word_count saturates at 2^AW.
- ext_addr wraps naturally, but the overflow rule ends the session before any reuse.

Optional Feature:
- Macro: WATCHDOG_EN.
- With the macro defined:
  - A counter runs in RUN.
  - If cpu_done has not been seen after WDT_CYCLES cycles: drive cpu_rst_n=0, set sticky output wdt_trip (1 bit, added port), go to IDLE.
  - wdt_trip clears on the next start or on reset.
- Without the macro: no counter and no wdt_trip port; RUN waits indefinitely for cpu_done.

Test Plan:
- Reset mid-LOAD:
  - Stimulus: after 3 words, drive PC_rst=0 for 1 cycle.
  - Required: all outputs return to reset values at once; word_count=0; cpu_rst_n=0.
- Normal load:
  - Stimulus: start, then words 16'h087F, 16'h0900, 16'hE001, one per cycle.
  - Required: ext_we pulses at addr 0, 1, 2 with matching data; word_count=3.
  - Required: cpu_rst_n low for exactly RST_HOLD=9 cycles after the last write, then high.
  - Required: cpu_done=1 -> finished=1; cpu_rst_n stays 1.
- Backpressure gaps:
  - Stimulus: in_valid toggled 1,0,0,1,1 with words A, B, C.
  - Required: exactly 3 writes at consecutive addresses; no write in idle cycles.
- Overflow:
  - Stimulus: AW=2, four non-HLT words.
  - Required: 4 writes (addr 0–3), load_err=1, state IDLE, cpu_rst_n=0, no HOLD.
- Reload from DONE:
  - Stimulus: start pulse.
  - Required: cpu_rst_n=0 next cycle; finished=0; next write lands at addr 0.
  - Required: start and cpu_done together in RUN -> DONE.
- WATCHDOG_EN:
  - Stimulus: WDT_CYCLES=50, cpu_done held 0.
  - Required: after 50 RUN cycles, wdt_trip=1, cpu_rst_n=0, state IDLE.
